// File: rtl/ram_fifo_ctrl.sv
// Controller that turns an 8x8 single-port synchronous RAM into an 8-entry FIFO.
// It has a valid/ready push side and a request/acknowledge pop side with registered pop data.
module ram_fifo_ctrl #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_valid_i,
    input  logic [DW-1:0] push_data_i,
    output logic          push_ready_o,
    input  logic          pop_req_i,
    output logic          pop_ack_o,
    output logic          pop_valid_o,
    output logic [DW-1:0] pop_data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ram_w_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_din_o,
    input  logic [DW-1:0] ram_dout_i
);

    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {IDLE, RDATA} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] pop_data_q, pop_data_d;
    logic          pop_valid_q, pop_valid_d;
    logic          push_fire;

    // Handshakes and RAM port; a push always owns the RAM port for its cycle
    always_comb begin
        full_o       = (count_q == CW'(DEPTH));
        empty_o      = (count_q == CW'(0));
        push_ready_o = !full_o && !clear_i;
        push_fire    = push_valid_i && push_ready_o;
        pop_ack_o    = pop_req_i && !empty_o && (state_q == IDLE) && !clear_i && !push_fire;
        ram_w_o      = push_fire;
        ram_addr_o   = push_fire ? wptr_q : rptr_q;
        ram_din_o    = push_fire ? push_data_i : DW'(0);
    end

    // Next-state logic; push and pop are mutually exclusive by construction of pop_ack
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            wptr_d  = AW'(0);
            rptr_d  = AW'(0);
            count_d = CW'(0);
        end else begin
            if (state_q == RDATA) begin
                pop_data_d  = ram_dout_i;
                pop_valid_d = 1'b1;
                state_d     = IDLE;
            end
            if (push_fire) begin
                wptr_d  = wptr_q + AW'(1);
                count_d = count_q + CW'(1);
            end else if (pop_ack_o) begin
                rptr_d  = rptr_q + AW'(1);
                count_d = count_q - CW'(1);
                state_d = RDATA;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wptr_q      <= AW'(0);
            rptr_q      <= AW'(0);
            count_q     <= CW'(0);
            pop_data_q  <= DW'(0);
            pop_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
        end
    end

    assign count_o     = count_q;
    assign pop_data_o  = pop_data_q;
    assign pop_valid_o = pop_valid_q;

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Initiator-side controller for the 8x8 single-port synchronous RAM. It drives the RAM's write-enable, address and write-data lines and consumes its registered read data, turning the raw array into an 8-entry FIFO with valid/ready push and request/acknowledge pop handshakes. It sits between user logic (switch/button front end, or any producer/consumer) and the RAM instance, and is the only master of the RAM port.

## Interface
- DW, 8, data width; must equal the RAM word width
- AW, 3, address width; depth = 2^AW = 8
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush; empties the FIFO in one cycle
- push_valid  in  1  producer has a word on push_data
- push_data  in  DW  word to store
- push_ready  out  1  controller accepts push this cycle (combinational)
- pop_req  in  1  consumer requests the oldest word
- pop_ack  out  1  pop accepted this cycle (combinational)
- pop_valid  out  1  registered one-cycle pulse; pop_data holds the popped word
- pop_data  out  DW  registered popped word; holds value until next pop_valid
- count  out  AW+1  stored words, 0..8
- full  out  1  count == 8
- empty  out  1  count == 0
- ram_w  out  1  RAM write enable (combinational)
- ram_addr  out  AW  RAM address (combinational)
- ram_din  out  DW  RAM write data (combinational)
- ram_dout  in  DW  RAM registered read data

## Operation
- Registers: wptr[AW-1:0], rptr[AW-1:0], count[AW:0], state {IDLE, RDATA}, pop_data, pop_valid.
- RAM contract: one op per cycle; write lands on the edge ram_w=1; when ram_w=0 the RAM loads ram_dout with mem[ram_addr] on that edge; a write cycle leaves ram_dout unchanged.
- push_ready = !full && !clear. Push fires when push_valid && push_ready: ram_w=1, ram_addr=wptr, ram_din=push_data; on the edge wptr += 1 (mod 8), count += 1.
- pop_ack = pop_req && !empty && state==IDLE && !clear && !(push fires). Push has priority over pop in the same cycle.
- Pop fires when pop_ack: ram_w=0, ram_addr=rptr; on the edge rptr += 1 (mod 8), count -= 1, state -> RDATA.
- RDATA (exactly one cycle): pop_data <= ram_dout, pop_valid <= 1 on the edge, state -> IDLE. A push may fire in RDATA; a pop may not.
- When no push fires: ram_w=0, ram_addr=rptr, ram_din=0. The resulting RAM reads are harmless.
- Push and pop firing in the same cycle is impossible, so count changes by at most 1 per cycle.
- clear: wptr, rptr, count <= 0 and state <= IDLE. A pending RDATA is cancelled: no pop_valid, and pop_data keeps its old value. RAM contents are not touched.
- Pointers wrap 7 -> 0 without affecting count. full and empty are decoded combinationally from count.

## Timing
- Reset (rst=0, asynchronous): wptr=0, rptr=0, count=0, state=IDLE, pop_valid=0, pop_data=0. Hence empty=1, full=0, push_ready=1 (unless clear), pop_ack=0, ram_w=0.
- Push latency: the word is stored at the accept edge and is poppable in the next cycle.
- Pop latency: pop_ack in cycle N; ram_dout valid in N+1; pop_valid=1 with pop_data in N+2.
- Pop throughput: one per 2 cycles. Push throughput: one per cycle.
- Full: push_ready=0 and push_data is ignored. A pop in the same cycle is accepted; push_ready rises the following cycle.
- Empty with pop_req: pop_ack=0. With push_valid and pop_req both high on empty, the push fires and the pop is acked the next cycle.
- rst asserted mid-RDATA: no pop_valid is ever produced for that pop.

## Test plan
- Reset then idle: count=0, empty=1, full=0, pop_valid=0, pop_data=0x00, ram_w=0.
- Push 0x11..0x88 on consecutive cycles: push_ready=1 for all 8, full=1 after the 8th, and a 9th push of 0x99 is refused with ram_w=0.
- Pop 8 times: pop_valid pulses 2 cycles after each pop_ack, data 0x11,0x22,...,0x88 in order, then empty=1 and pop_ack=0.
- Wrap: push 5, pop 5, push 6 (0xA0..0xA5), pop 6. Data matches in order and ram_addr wraps 7->0 on both pointers.
- Push and pop together at count=3: push fires, pop_ack=0, count=4; the pop is acked the next cycle and count returns to 3.
- clear in the RDATA cycle after a pop: count=0, no pop_valid pulse, pop_data unchanged. Separately, rst pulsed low mid-stream drives all outputs to reset values immediately, with no clock edge needed.
